inst_fetch_buf: RTL

Instruction-fetch buffer between the PC generator and the decode stage. It takes the fetch address (`pc`, `ce`) and issues in-order requests to instruction memory over a valid/ready channel. Returned instructions are paired with their PC in a DEPTH-entry in-order queue and presented to ID over a valid/ready handshake. The block applies back-pressure to the PC generator through `pc_stall`, and on `flush` it discards all queued and in-flight fetches.

---
 rtl/inst_fetch_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/inst_fetch_buf.sv
// Instruction-fetch buffer: issues in-order fetches to instruction memory and
// pairs each returned instruction with its PC in an in-order queue toward ID.
module inst_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          ce,
    output logic          pc_stall,
    input  logic          flush,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    pc_q   [DEPTH];
    logic [DW-1:0]    inst_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    head, fptr, tail;
    logic [CW-1:0]    count, pend, discard;

    logic          credit, alloc, pop, rsp_drop, rsp_fill;
    logic [CW:0]   occ;

    // Credit looks only at registered occupancy, so id_ready never reaches mem_req_valid.
    always_comb begin
        occ    = {1'b0, count} + {1'b0, discard};
        credit = occ < (CW+1)'(DEPTH);
    end

    assign mem_req_valid = ce & credit & ~flush;
    assign mem_addr      = pc;
    assign alloc         = mem_req_valid & mem_req_ready;
    assign pc_stall      = ce & ~alloc;

    assign id_valid = filled[head] & ~flush;
    assign id_pc    = id_valid ? pc_q[head]   : '0;
    assign id_inst  = id_valid ? inst_q[head] : '0;
    assign pop      = id_valid & id_ready;

    // pend counts allocated entries still waiting for their response.
    assign rsp_drop = mem_rsp_valid & (discard != '0);
    assign rsp_fill = mem_rsp_valid & (discard == '0) & (pend != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            filled  <= '0;
            head    <= '0;
            fptr    <= '0;
            tail    <= '0;
            count   <= '0;
            pend    <= '0;
            discard <= '0;
        end else if (flush) begin
            // Responses still owed for unfilled entries become discards.
            filled  <= '0;
            head    <= '0;
            fptr    <= '0;
            tail    <= '0;
            count   <= '0;
            pend    <= '0;
            discard <= discard - CW'(rsp_drop) + pend - CW'(rsp_fill);
        end else begin
            if (pop)
                filled[head] <= 1'b0;
            if (rsp_fill)
                filled[fptr] <= 1'b1;
            head    <= head + PW'(pop);
            fptr    <= fptr + PW'(rsp_fill);
            tail    <= tail + PW'(alloc);
            count   <= count + CW'(alloc) - CW'(pop);
            pend    <= pend + CW'(alloc) - CW'(rsp_fill);
            discard <= discard - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            pc_q[tail] <= pc;
        if (rsp_fill)
            inst_q[fptr] <= mem_rsp_data;
    end

endmodule
